insn_encoder: RTL and testbench
===============================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port resetBar, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port reqValid, input, 1 bit: an instruction request is present.
REQ-004 SHALL have port reqReady, output, 1 bit: the encoder accepts a request this cycle.
REQ-005 SHALL have port reqDest, input, 3 bits: destination field (0 IR, 2 A, 3 B, 4 X, 5 mem, 6 Q, 7 PC).
REQ-006 SHALL have port reqSource, input, 3 bits: source field (0 ROM immediate, 2 A, 3 B, 4 X, 5 RAM, 6 E/ALU, 7 S/shift).
REQ-007 SHALL have port reqMode, input, 2 bits: {bit7,bit3}; sets the ALU controls (subtract/carry-in/shift-in), or the jump condition when reqDest==7 (0 unconditional, 1 zero, 2 carry, 3 shift).
REQ-008 SHALL have port reqImm, input, 8 bits: immediate byte, used only when reqSource==0.
REQ-009 SHALL have port byteOut, output, 8 bits: the program byte presented to the fetch side.
REQ-010 SHALL have port byteValid, output, 1 bit: byteOut is meaningful.
REQ-011 SHALL have port byteIsImm, output, 1 bit: byteOut is an immediate operand, not an opcode.
REQ-012 SHALL have port byteTake, input, 1 bit: the consumer accepts byteOut this cycle.
REQ-013 SHALL have port errIllegal, output, 1 bit: sticky flag, set when an illegal request has been seen.
REQ-014 SHALL have port insnCount, output, 8 bits: count of opcode bytes taken.
REQ-015 SHALL have port fifoLevel, output, 3 bits: occupied FIFO entries, range 0..4.

Function
REQ-016 SHALL encode each opcode as {reqMode[1], reqDest, reqMode[0], reqSource}, exactly inverse to the CPU control decode.
REQ-017 SHALL buffer requests in a 4-entry FIFO; each entry holds {opcode[7:0], imm[7:0]}.
REQ-018 SHALL drive reqReady = (fifoLevel<4), combinationally; when full, reqReady SHALL stay low even if a pop occurs in the same cycle.
REQ-019 SHALL treat a request with reqDest==1 or reqSource==1 as illegal: it is consumed, not pushed, sets errIllegal, and leaves fifoLevel unchanged.
REQ-020 SHALL run an output FSM with three states: IDLE, OPC, IMM.
REQ-021 SHALL go from IDLE to OPC at the edge after fifoLevel becomes nonzero, giving one cycle of accept-to-byteValid latency.
REQ-022 In OPC, SHALL drive byteOut = head opcode, byteValid=1, byteIsImm=0.
REQ-023 On byteTake in OPC with head source==0, SHALL go to IMM without popping.
REQ-024 On byteTake in OPC with any other head source, SHALL pop the head, then go to OPC if entries remain, else to IDLE.
REQ-025 In IMM, SHALL drive byteOut = head imm, byteValid=1, byteIsImm=1; byteTake SHALL pop the head and go to OPC or IDLE by the same rule as REQ-024.
REQ-026 In IDLE, SHALL drive byteValid=0, byteIsImm=0, byteOut=8'h00; byteTake SHALL be ignored.
REQ-027 Holding rule: while byteTake=0, SHALL hold byteOut and byteValid stable.
REQ-028 Simultaneous push and pop SHALL leave fifoLevel unchanged; FIFO pointers SHALL wrap modulo 4.
REQ-029 SHALL increment insnCount on each byteTake in OPC, wrapping 255->0; immediate bytes SHALL NOT count.

Reset
REQ-030 Asserting resetBar low SHALL immediately force: FIFO empty, FSM IDLE, byteValid=0, byteIsImm=0, byteOut=0, errIllegal=0, insnCount=0, fifoLevel=0, reqReady=1.
REQ-031 Reset in the middle of a two-byte instruction SHALL discard the pending immediate; after release, the first byte presented SHALL be an opcode.
REQ-032 The FSM SHALL leave IDLE no earlier than the second rising edge after resetBar deasserts.

Verification
REQ-033 Request dest=2, src=3, mode=0 with byteTake held high -> byteOut=8'h23, byteIsImm=0 one cycle later; insnCount=1; fifoLevel returns to 0.
REQ-034 Request dest=2, src=0, imm=8'hA5 -> byteOut=8'h20, then 8'hA5 with byteIsImm=1; insnCount=1.
REQ-035 Request dest=7, src=0, mode=2, imm=8'h10 -> bytes 8'hF0, then 8'h10.
REQ-036 Five requests with byteTake=0 -> reqReady low after the 4th; fifoLevel=4; after draining, the bytes appear in order.
REQ-037 Request dest=1 -> consumed, errIllegal=1 and stays set, fifoLevel=0, byteValid stays 0.
REQ-038 256 single-byte instructions taken -> insnCount wraps to 0; pulsing resetBar during IMM -> all outputs return to their reset values.

Source files
------------

// File: rtl/insn_encoder.sv
// Instruction byte encoder: buffers requests in a 4-deep FIFO and streams
// opcode bytes, plus an immediate byte for ROM-sourced moves, to the fetch side.
module insn_encoder (
    input  logic       clk,
    input  logic       resetBar,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [2:0] reqDest,
    input  logic [2:0] reqSource,
    input  logic [1:0] reqMode,
    input  logic [7:0] reqImm,
    output logic [7:0] byteOut,
    output logic       byteValid,
    output logic       byteIsImm,
    input  logic       byteTake,
    output logic       errIllegal,
    output logic [7:0] insnCount,
    output logic [2:0] fifoLevel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPC,
        S_IMM
    } state_e;

    state_e          state_q, state_d;
    logic [3:0][15:0] mem_q, mem_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      level_q, level_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic        accept;
    logic        illegal;
    logic        push;
    logic        pop;
    logic [7:0]  opcode;
    logic [15:0] head;
    logic        head_has_imm;

    assign reqReady     = (level_q != 3'd4);
    assign accept       = reqValid && reqReady;
    assign illegal      = (reqDest == 3'd1) || (reqSource == 3'd1);
    assign push         = accept && !illegal;
    assign opcode       = {reqMode[1], reqDest, reqMode[0], reqSource};
    assign head         = mem_q[rd_ptr_q];
    assign head_has_imm = (head[10:8] == 3'd0);

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cnt_d     = cnt_q;
        byteOut   = 8'h00;
        byteValid = 1'b0;
        byteIsImm = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != 3'd0) state_d = S_OPC;
            end
            S_OPC: begin
                byteOut   = head[15:8];
                byteValid = 1'b1;
                if (byteTake) begin
                    cnt_d = cnt_q + 8'd1;
                    if (head_has_imm) state_d = S_IMM;
                    else              pop     = 1'b1;
                end
            end
            S_IMM: begin
                byteOut   = head[7:0];
                byteValid = 1'b1;
                byteIsImm = 1'b1;
                if (byteTake) pop = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        level_d  = level_q + 3'(push) - 3'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {opcode, reqImm};
        // A same-cycle push keeps the stream going without an idle bubble
        if (pop) state_d = (level_d != 3'd0) ? S_OPC : S_IDLE;
        err_d = err_q || (accept && illegal);
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_q  <= S_IDLE;
            mem_q    <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign errIllegal = err_q;
    assign insnCount  = cnt_q;
    assign fifoLevel  = level_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: randomized and directed requests,
// expected byte stream modelled from the opcode field layout.
module tb_insn_encoder;

    logic       clk = 1'b0;
    logic       resetBar = 1'b1;
    logic       reqValid = 1'b0;
    logic       reqReady;
    logic [2:0] reqDest = 3'd0;
    logic [2:0] reqSource = 3'd0;
    logic [1:0] reqMode = 2'd0;
    logic [7:0] reqImm = 8'd0;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       byteIsImm;
    logic       byteTake = 1'b0;
    logic       errIllegal;
    logic [7:0] insnCount;
    logic [2:0] fifoLevel;

    typedef struct {
        bit       imm;
        bit [7:0] b;
        bit       last;
    } exp_t;

    exp_t     exp_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       lvl = 0;
    bit       err_m = 1'b0;
    bit [7:0] cnt_m = 8'd0;
    int       take_mode = 0;
    int       n_ops = 0;

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk(clk),
        .resetBar(resetBar),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqDest(reqDest),
        .reqSource(reqSource),
        .reqMode(reqMode),
        .reqImm(reqImm),
        .byteOut(byteOut),
        .byteValid(byteValid),
        .byteIsImm(byteIsImm),
        .byteTake(byteTake),
        .errIllegal(errIllegal),
        .insnCount(insnCount),
        .fifoLevel(fifoLevel)
    );

    function automatic bit [7:0] enc(input int d, input int s, input int m);
        return 8'((m / 2) * 128 + d * 16 + (m % 2) * 8 + s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired or no expectation at %0t", nm, $time);
    endtask

    task automatic send(input int d, input int s, input int m, input int im);
        int t = 0;
        reqValid  = 1'b1;
        reqDest   = 3'(d);
        reqSource = 3'(s);
        reqMode   = 2'(m);
        reqImm    = 8'(im);
        @(negedge clk);
        while (!reqReady && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!reqReady) begin
            fail("send_timeout");
        end else if (d != 1 && s != 1) begin
            exp_q.push_back('{imm: 1'b0, b: enc(d, s, m), last: (s != 0)});
            if (s == 0) exp_q.push_back('{imm: 1'b1, b: 8'(im), last: 1'b1});
            n_ops++;
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || lvl != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetBar = 1'b0;
        reqValid = 1'b0;
        #1;
        chk("rst_valid", byteValid, 1'b0);
        chk("rst_isimm", byteIsImm, 1'b0);
        chk("rst_byte", byteOut, 8'h00);
        chk("rst_err", errIllegal, 1'b0);
        chk("rst_count", insnCount, 8'd0);
        chk("rst_level", fifoLevel, 3'd0);
        chk("rst_ready", reqReady, 1'b1);
        @(posedge clk);
        #1;
        resetBar = 1'b1;
        n_ops = 0;
    endtask

    task automatic take_drv();
        forever begin
            @(posedge clk);
            #1;
            if (take_mode == 0)      byteTake = 1'b0;
            else if (take_mode == 1) byteTake = 1'b1;
            else if (take_mode == 2) byteTake = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic monitor();
        exp_t     e;
        bit       pv = 1'b0;
        bit       pt = 1'b0;
        bit [7:0] pb = 8'd0;
        forever begin
            @(negedge clk);
            if (!resetBar) begin
                exp_q.delete();
                lvl   = 0;
                err_m = 1'b0;
                cnt_m = 8'd0;
                pv    = 1'b0;
                pt    = 1'b0;
            end else begin
                chk("ready", reqReady, lvl < 4);
                chk("level", fifoLevel, lvl);
                chk("err", errIllegal, err_m);
                chk("count", insnCount, cnt_m);
                if (pv && !pt) begin
                    chk("hold_valid", byteValid, 1'b1);
                    chk("hold_byte", byteOut, pb);
                end
                if (!byteValid) chk("idle_byte", {byteIsImm, byteOut}, 9'd0);
                if (byteValid && byteTake) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_byte");
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", {byteIsImm, byteOut}, {e.imm, e.b});
                        if (!e.imm) cnt_m++;
                        if (e.last) lvl--;
                    end
                end
                if (reqValid && reqReady) begin
                    if (reqDest == 3'd1 || reqSource == 3'd1) err_m = 1'b1;
                    else                                       lvl++;
                end
                pv = byteValid;
                pt = byteTake;
                pb = byteOut;
            end
        end
    endtask

    initial begin
        int d;
        int s;
        int t;
        fork
            monitor();
            take_drv();
        join_none
        #2;
        do_reset();

        // single-byte move with consumer always ready
        take_mode = 1;
        send(2, 3, 0, 0);
        @(negedge clk);
        chk("lat_idle", byteValid, 1'b0);
        @(negedge clk);
        chk("lat_opc_valid", byteValid, 1'b1);
        chk("lat_opc_byte", byteOut, 8'h23);
        drain();
        chk("c033_count", insnCount, 8'd1);
        chk("c033_level", fifoLevel, 3'd0);

        send(2, 0, 0, 8'hA5);
        drain();
        chk("c034_count", insnCount, 8'd2);
        send(7, 0, 2, 8'h10);
        drain();

        // fill the FIFO with the consumer stalled
        take_mode = 0;
        @(posedge clk);
        #1;
        send(2, 3, 1, 0);
        send(3, 4, 0, 0);
        send(4, 0, 3, 8'h5A);
        send(5, 6, 2, 0);
        @(negedge clk);
        chk("full_level", fifoLevel, 3'd4);
        chk("full_ready", reqReady, 1'b0);
        @(posedge clk);
        #1;
        fork
            send(6, 7, 1, 0);
            begin
                repeat (6) @(posedge clk);
                #1;
                take_mode = 1;
            end
        join
        drain();

        // illegal request
        send(1, 3, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("ill_err", errIllegal, 1'b1);
            chk("ill_level", fifoLevel, 3'd0);
            chk("ill_valid", byteValid, 1'b0);
        end
        @(posedge clk);
        #1;

        // randomized traffic
        take_mode = 2;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 7));
            s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 7));
            if ($urandom_range(0, 31) == 0) d = 1;
            if ($urandom_range(0, 31) == 0) s = 1;
            send(d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        // counter wrap
        take_mode = 1;
        for (int i = 0; i < 256; i++)
            send(int'($urandom_range(2, 7)), int'($urandom_range(2, 7)),
                 int'($urandom_range(0, 3)), 0);
        drain();
        chk("wrap_count", insnCount, 8'(n_ops));

        // reset while the immediate byte is pending
        take_mode = 3;
        @(posedge clk);
        #1;
        byteTake = 1'b0;
        send(2, 0, 1, 8'hC3);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!byteValid && t < 20);
        if (!byteValid) fail("imm_wait");
        @(posedge clk);
        #1;
        byteTake = 1'b1;
        @(posedge clk);
        #1;
        byteTake = 1'b0;
        @(negedge clk);
        chk("imm_isimm", byteIsImm, 1'b1);
        chk("imm_byte", byteOut, 8'hC3);
        @(posedge clk);
        #1;
        do_reset();
        take_mode = 1;
        send(3, 2, 0, 0);
        drain();
        chk("post_rst_count", insnCount, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
